// File: rtl/q44_pkg.sv
// Shared types and constants for the Q(IW,FW) sequential multiplier.
package q44_pkg;

   localparam int DEF_IW      = 4;
   localparam int DEF_FW      = 4;
   localparam int DEF_DW      = DEF_IW + DEF_FW;
   localparam int DEF_ROUND_K = 1 << (DEF_FW - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Half an output LSB in the double-width product (round-half-up constant).
   function automatic int round_const(input int fw);
      return 1 << (fw - 1);
   endfunction

endpackage

// File: rtl/q88_to_q44.sv
// Rounds a Q(2IW,2FW) product to Q(IW,FW) with overflow detect.
// Q44_SEQ_MULT_SAT_EN: saturate to all ones on overflow; otherwise wrap.
module q88_to_q44
   import q44_pkg::*;
#(
   parameter int IW = DEF_IW,
   parameter int FW = DEF_FW
) (
   input  logic [2*(IW+FW)-1:0] acc_i,
   output logic [IW+FW-1:0]     p_o,
   output logic                 ovf_o
);

   localparam int DW  = IW + FW;
   localparam int AW  = 2 * DW;
   localparam int TOP = 2*FW + IW - 1;

   logic [AW-1:0] rnd;
   logic [DW-1:0] wrapped;

   // The largest product plus the rounding constant still fits in AW bits.
   assign rnd     = acc_i + AW'(round_const(FW));
   assign wrapped = rnd[TOP:FW];
   assign ovf_o   = |rnd[AW-1:TOP+1];

`ifdef Q44_SEQ_MULT_SAT_EN
   assign p_o = ovf_o ? {DW{1'b1}} : wrapped;
`else
   assign p_o = wrapped;
`endif

endmodule

// File: rtl/q44_seq_mult.sv
// Shift-add unsigned Q(IW,FW) multiplier, one multiplier bit per cycle, valid/ready ports.
// Q44_SEQ_MULT_SAT_EN selects saturating instead of wrapping output on overflow.
module q44_seq_mult
   import q44_pkg::*;
#(
   parameter int IW = DEF_IW,
   parameter int FW = DEF_FW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IW+FW-1:0]  a,
   input  logic [IW+FW-1:0]  b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IW+FW-1:0]  p,
   output logic              ovf
);

   localparam int DW = IW + FW;
   localparam int AW = 2 * DW;
   localparam int CW = $clog2(DW + 1);

   state_t        state_q, state_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [AW-1:0] mcand_q, mcand_d;
   logic [DW-1:0] mplier_q, mplier_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] p_q, p_d;
   logic          ovf_q, ovf_d;

   logic [DW-1:0] rnd_p;
   logic          rnd_ovf;
   logic          accept;
   logic          run_step;
   logic          run_last;
   logic          out_fire;

   assign accept   = (state_q == ST_IDLE) && in_valid;
   assign run_step = (state_q == ST_RUN) && (cnt_q != '0);
   assign run_last = (state_q == ST_RUN) && (cnt_q == '0);
   assign out_fire = (state_q == ST_DONE) && out_ready;

   q88_to_q44 #(
      .IW(IW),
      .FW(FW)
   ) u_round (
      .acc_i (acc_q),
      .p_o   (rnd_p),
      .ovf_o (rnd_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == '0) state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      p_d      = p_q;
      ovf_d    = ovf_q;
      if (accept) begin
         acc_d    = '0;
         mcand_d  = {{DW{1'b0}}, a};
         mplier_d = b;
         cnt_d    = CW'(DW);
      end else if (run_step) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CW'(1);
      end else if (run_last) begin
         // Result is frozen here so p/ovf stay stable for the whole DONE stall.
         p_d   = rnd_p;
         ovf_d = rnd_ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         p_q      <= '0;
         ovf_q    <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         p_q      <= p_d;
         ovf_q    <= ovf_d;
      end
   end

   assign p   = p_q;
   assign ovf = ovf_q;

   // out_fire is the result handshake; kept explicit for readability of the FSM.
   logic unused_fire;
   assign unused_fire = out_fire;

endmodule

// File: tb/tb_q44_seq_mult.sv
// Scoreboard bench for q44_seq_mult: directed vectors, stall and reset-abort cases.
module tb_q44_seq_mult;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] p;
   logic       ovf;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];

`ifdef Q44_SEQ_MULT_SAT_EN
   localparam logic [7:0] FF_P = 8'hFF;
   localparam logic [7:0] OV_P = 8'hFF;
`else
   localparam logic [7:0] FF_P = 8'hE0;
   localparam logic [7:0] OV_P = 8'h00;
`endif

   always #5 clk = ~clk;

   q44_seq_mult dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .ovf       (ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every result handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got p=%h ovf=%b expected none", p, ovf);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            $display("txn: p=%h ovf=%b (expected p=%h ovf=%b)", p, ovf, e[8:1], e[0]);
            check("result_p", {24'd0, p}, {24'd0, e[8:1]});
            check("result_ovf", {31'd0, ovf}, {31'd0, e[0]});
         end
      end
   end

   // Called at #1 after a rising edge; returns after the acceptance edge (+#1).
   task automatic issue(input logic [7:0] ai, input logic [7:0] bi, input logic push,
                        input logic [7:0] ep, input logic eo);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b1;
      a        = ai;
      b        = bi;
      if (push) exp_q.push_back({ep, eo});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("accepted_in_ready_low", {31'd0, in_ready}, 32'd0);
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_vec(input logic [7:0] ai, input logic [7:0] bi,
                          input logic [7:0] ep, input logic eo);
      int lat;
      issue(ai, bi, 1'b1, ep, eo);
      wait_out(lat);
      check("latency", lat, 32'd9);
      @(posedge clk);
      #1;
      check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int lat;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      #2;
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_p", {24'd0, p}, 32'd0);
      check("reset_ovf", {31'd0, ovf}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_vec(8'h18, 8'h20, 8'h30, 1'b0);
      run_vec(8'h11, 8'h11, 8'h12, 1'b0);
      run_vec(8'h01, 8'h08, 8'h01, 1'b0);
      run_vec(8'h01, 8'h07, 8'h00, 1'b0);
      run_vec(8'hFF, 8'hFF, FF_P,  1'b1);
      run_vec(8'h3F, 8'h40, 8'hFC, 1'b0);
      run_vec(8'h40, 8'h40, OV_P,  1'b1);
      run_vec(8'h00, 8'hFF, 8'h00, 1'b0);

      // Stall in DONE while the input side is noisy.
      out_ready = 1'b0;
      issue(8'h11, 8'h11, 1'b1, 8'h12, 1'b0);
      wait_out(lat);
      check("stall_latency", lat, 32'd9);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         a        = 8'($urandom);
         b        = 8'($urandom);
         @(posedge clk);
         #1;
         check("stall_out_valid", {31'd0, out_valid}, 32'd1);
         check("stall_p", {24'd0, p}, 32'h12);
         check("stall_ovf", {31'd0, ovf}, 32'd0);
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("post_stall_in_ready", {31'd0, in_ready}, 32'd1);
      check("post_stall_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      check("no_stray_operand", {31'd0, out_valid}, 32'd0);

      // Abort mid-RUN with reset; no result may appear for this operation.
      issue(8'hFF, 8'h18, 1'b0, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_p", {24'd0, p}, 32'd0);
      check("abort_ovf", {31'd0, ovf}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_vec(8'h10, 8'h10, 8'h10, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
